// File: rtl/mac_seq.sv
// mac_seq: iterative radix-4 Booth multiply-accumulate; SLICE_BITS multiplier bits retired per MULT cycle.
// Define MAC_EARLY_TERM_EN to leave MULT as soon as the remaining multiplier bits are pure sign.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// MULT  | one Booth slice compressed into sum/carry per cycle
// ADD   | resolve sum+carry into result and flags
// DONE  | result held until out_ready
module mac_seq #(
    parameter int OP_W       = 32,
    parameter int SLICE_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     op_a,
    input  logic [OP_W-1:0]     op_b,
    input  logic [2*OP_W-1:0]   acc_in,
    input  logic                is_signed,
    input  logic                is_long,
    input  logic                accumulate,
    input  logic                cancel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*OP_W-1:0]   result,
    output logic                flag_n,
    output logic                flag_z
);
    localparam int NSLICE = OP_W / SLICE_BITS;
    localparam int PW     = 2 * OP_W;
    localparam int BW     = OP_W + 3;
    localparam int DIG    = SLICE_BITS / 2;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, MULT, ADD, DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   a_q, a_d, sum_q, sum_d, carry_q, carry_d, result_q, result_d;
    logic [BW-1:0]   b_q, b_d;
    logic [KW-1:0]   k_q, k_d;
    logic            is_long_q, is_long_d, flag_n_q, flag_n_d, flag_z_q, flag_z_d;

    logic [PW-1:0]   csa_s, csa_c, pp, corr, mag, sum_full;
    logic [2:0]      trip;
    logic            neg, early, b_sign;
    int              pos;

    // b_q holds op_b_ext shifted up by one, so b_q[0] is the implicit bit -1.
    // The extra digit at OP_W in the last slice corrects an unsigned top bit.
    always_comb begin
        csa_s = sum_q;
        csa_c = carry_q;
        corr  = '0;
        pp    = '0;
        mag   = '0;
        trip  = '0;
        neg   = 1'b0;
        pos   = 0;
        for (int j = 0; j <= DIG; j++) begin
            pos = (j < DIG) ? int'(k_q) * SLICE_BITS + 2 * j : OP_W;
            if (j < DIG || k_q == K_LAST) trip = b_q[pos +: 3];
            else                          trip = 3'b000;
            case (trip)
                3'b001, 3'b010, 3'b101, 3'b110: mag = a_q;
                3'b011, 3'b100:                 mag = a_q << 1;
                default:                        mag = '0;
            endcase
            neg  = trip[2] & ~(trip[1] & trip[0]);
            pp   = (mag ^ {PW{neg}}) << pos;
            corr = corr | ({{(PW-1){1'b0}}, neg} << pos);
            {csa_s, csa_c} = {csa_s ^ csa_c ^ pp,
                              ((csa_s & csa_c) | (csa_s & pp) | (csa_c & pp)) << 1};
        end
        {csa_s, csa_c} = {csa_s ^ csa_c ^ corr,
                          ((csa_s & csa_c) | (csa_s & corr) | (csa_c & corr)) << 1};
    end

`ifdef MAC_EARLY_TERM_EN
    logic hi_zero, hi_one;
    always_comb begin
        hi_zero = 1'b1;
        hi_one  = 1'b1;
        for (int i = 0; i < BW; i++) begin
            if (i >= (int'(k_q) + 1) * SLICE_BITS) begin
                hi_zero = hi_zero & ~b_q[i];
                hi_one  = hi_one & b_q[i];
            end
        end
        early = hi_zero | hi_one;
    end
`else
    assign early = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        k_d       = k_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        is_long_d = is_long_q;
        result_d  = result_q;
        flag_n_d  = flag_n_q;
        flag_z_d  = flag_z_q;
        b_sign    = is_signed & op_b[OP_W-1];
        sum_full  = sum_q + carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d       = is_signed ? {{OP_W{op_a[OP_W-1]}}, op_a} : {{OP_W{1'b0}}, op_a};
                    b_d       = {{2{b_sign}}, op_b, 1'b0};
                    is_long_d = is_long;
                    sum_d     = !accumulate ? '0 :
                                is_long ? acc_in : {{OP_W{1'b0}}, acc_in[OP_W-1:0]};
                    carry_d   = '0;
                    k_d       = '0;
                    state_d   = MULT;
                end
            end
            MULT: begin
                sum_d   = csa_s;
                carry_d = csa_c;
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST || early) state_d = ADD;
            end
            ADD: begin
                result_d = is_long_q ? sum_full : {{OP_W{1'b0}}, sum_full[OP_W-1:0]};
                flag_n_d = is_long_q ? sum_full[PW-1] : sum_full[OP_W-1];
                flag_z_d = is_long_q ? (sum_full == '0) : (sum_full[OP_W-1:0] == '0);
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (cancel) begin
            state_d  = IDLE;
            result_d = result_q;
            flag_n_d = flag_n_q;
            flag_z_d = flag_z_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            k_q       <= '0;
            sum_q     <= '0;
            carry_q   <= '0;
            is_long_q <= 1'b0;
            result_q  <= '0;
            flag_n_q  <= 1'b0;
            flag_z_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            k_q       <= k_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            is_long_q <= is_long_d;
            result_q  <= result_d;
            flag_n_q  <= flag_n_d;
            flag_z_q  <= flag_z_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign flag_n    = flag_n_q;
    assign flag_z    = flag_z_q;
endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq: table of hand-computed products, plus cancel, backpressure and reset sequences.
// A second instance with SLICE_BITS=16 runs the same operations in lockstep.
module tb_mac_seq;
    logic        clk = 1'b0;
    logic        reset, in_valid, is_signed, is_long, accumulate, cancel, out_ready;
    logic [31:0] op_a, op_b;
    logic [63:0] acc_in;
    logic        in_ready, out_valid, flag_n, flag_z;
    logic [63:0] result;
    logic        in_ready16, out_valid16, flag_n16, flag_z16;
    logic [63:0] result16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_seq #(.OP_W(32), .SLICE_BITS(8)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .acc_in(acc_in), .is_signed(is_signed),
        .is_long(is_long), .accumulate(accumulate), .cancel(cancel),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_n(flag_n), .flag_z(flag_z)
    );

    mac_seq #(.OP_W(32), .SLICE_BITS(16)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready16),
        .op_a(op_a), .op_b(op_b), .acc_in(acc_in), .is_signed(is_signed),
        .is_long(is_long), .accumulate(accumulate), .cancel(cancel),
        .out_valid(out_valid16), .out_ready(out_ready), .result(result16),
        .flag_n(flag_n16), .flag_z(flag_z16)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] acc;
        logic        sgn;
        logic        lng;
        logic        accum;
        logic [63:0] exp_res;
        logic        exp_n;
        logic        exp_z;
        int          lat8_et;
        int          lat16_et;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        @(negedge clk);
        for (int w = 0; w < 30 && !(in_ready && in_ready16); w++) @(negedge clk);
        chk("idle before op", {63'd0, in_ready & in_ready16}, 64'd1);
    endtask

    task automatic drive_op(input vec_t v);
        op_a       = v.a;
        op_b       = v.b;
        acc_in     = v.acc;
        is_signed  = v.sgn;
        is_long    = v.lng;
        accumulate = v.accum;
        in_valid   = 1'b1;
    endtask

    task automatic run_op(input vec_t v, output int lat8, output int lat16);
        wait_idle();
        drive_op(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat8  = -1;
        lat16 = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (out_valid && lat8 < 0)   lat8 = n;
            if (out_valid16 && lat16 < 0) lat16 = n;
            if (lat8 >= 0 && lat16 >= 0) break;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat8, lat16, exp8, exp16, seen;
        logic [63:0] prev_res;
        logic        prev_n;
        vec_t v;

        vecs[0]  = '{32'h7,        32'h6,        64'h0,                 1'b0, 1'b0, 1'b0, 64'h2A,                 1'b0, 1'b0, 2, 2};
        vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0,                 1'b0, 1'b1, 1'b0, 64'hFFFFFFFE00000001,   1'b1, 1'b0, 5, 3};
        vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0,                 1'b1, 1'b1, 1'b0, 64'h1,                  1'b0, 1'b0, 2, 2};
        vecs[3]  = '{32'h80000000, 32'h2,        64'h0000000100000000,  1'b1, 1'b1, 1'b1, 64'h0,                  1'b0, 1'b1, 2, 2};
        vecs[4]  = '{32'h10000,    32'h10000,    64'h1,                 1'b0, 1'b0, 1'b1, 64'h1,                  1'b0, 1'b0, 4, 3};
        vecs[5]  = '{32'h5,        32'h3,        64'h0,                 1'b1, 1'b1, 1'b0, 64'hF,                  1'b0, 1'b0, 2, 2};
        vecs[6]  = '{32'h5,        32'hFFFFFFFE, 64'h0,                 1'b1, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF6,   1'b1, 1'b0, 2, 2};
        vecs[7]  = '{32'h1,        32'h01000000, 64'h0,                 1'b1, 1'b1, 1'b0, 64'h01000000,           1'b0, 1'b0, 5, 3};
        vecs[8]  = '{32'hFFFFFFFD, 32'h4,        64'hDEADBEEF00000002,  1'b1, 1'b0, 1'b1, 64'h00000000FFFFFFF6,   1'b1, 1'b0, 2, 2};
        vecs[9]  = '{32'h10000,    32'h10000,    64'h0,                 1'b0, 1'b0, 1'b0, 64'h0,                  1'b0, 1'b1, 4, 3};
        vecs[10] = '{32'hFFFFFFFF, 32'h2,        64'h1,                 1'b0, 1'b1, 1'b1, 64'h1FFFFFFFF,          1'b0, 1'b0, 2, 2};
        vecs[11] = '{32'h80000000, 32'h80000000, 64'h0,                 1'b1, 1'b1, 1'b0, 64'h4000000000000000,   1'b0, 1'b0, 5, 3};
        vecs[12] = '{32'hFFFFFFFF, 32'h80000000, 64'h0,                 1'b0, 1'b1, 1'b0, 64'h7FFFFFFF80000000,   1'b0, 1'b0, 5, 3};

        reset = 1'b1; in_valid = 1'b0; is_signed = 1'b0; is_long = 1'b0; accumulate = 1'b0;
        cancel = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0; acc_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready",  {63'd0, in_ready},  64'd1);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset result",    result,             64'd0);
        chk("reset flag_n",    {63'd0, flag_n},    64'd0);
        chk("reset flag_z",    {63'd0, flag_z},    64'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i], lat8, lat16);
`ifdef MAC_EARLY_TERM_EN
            exp8  = vecs[i].lat8_et;
            exp16 = vecs[i].lat16_et;
`else
            exp8  = 5;
            exp16 = 3;
`endif
            chk($sformatf("v%0d latency", i),    64'(lat8),          64'(exp8));
            chk($sformatf("v%0d latency16", i),  64'(lat16),         64'(exp16));
            chk($sformatf("v%0d result", i),     result,             vecs[i].exp_res);
            chk($sformatf("v%0d result16", i),   result16,           vecs[i].exp_res);
            chk($sformatf("v%0d flag_n", i),     {63'd0, flag_n},    {63'd0, vecs[i].exp_n});
            chk($sformatf("v%0d flag_z", i),     {63'd0, flag_z},    {63'd0, vecs[i].exp_z});
            chk($sformatf("v%0d flag_n16", i),   {63'd0, flag_n16},  {63'd0, vecs[i].exp_n});
        end

        // cancel in the second MULT cycle
        prev_res = result;
        prev_n   = flag_n;
        wait_idle();
        drive_op(vecs[1]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel in_ready",   {63'd0, in_ready},   64'd1);
        chk("cancel in_ready16", {63'd0, in_ready16}, 64'd1);
        chk("cancel out_valid",  {63'd0, out_valid},  64'd0);
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (out_valid || out_valid16) seen = 1;
        end
        chk("cancel no out_valid", 64'(seen), 64'd0);
        chk("cancel result kept",  result, prev_res);
        chk("cancel flag_n kept",  {63'd0, flag_n}, {63'd0, prev_n});

        // backpressure: hold DONE for three cycles with a competing request
        out_ready = 1'b0;
        v = '{32'h12345678, 32'h10, 64'h0, 1'b0, 1'b1, 1'b0, 64'h123456780, 1'b0, 1'b0, 0, 0};
        wait_idle();
        drive_op(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 20 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("bp out_valid", {63'd0, out_valid}, 64'd1);
        op_a = 32'd3; op_b = 32'd5; acc_in = '0; is_signed = 1'b0; is_long = 1'b0; accumulate = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d result", n),    result,               64'h123456780);
            chk($sformatf("bp%0d in_ready", n),  {63'd0, in_ready},    64'd0);
            chk($sformatf("bp%0d out_valid", n), {63'd0, out_valid},   64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release in_ready",  {63'd0, in_ready},  64'd1);
        chk("bp release out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp accept in_ready", {63'd0, in_ready}, 64'd0);
        for (int n = 0; n < 20 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("bp second result", result, 64'hF);

        // reset in the middle of MULT
        wait_idle();
        drive_op(vecs[1]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid reset in_ready",  {63'd0, in_ready},  64'd1);
        chk("mid reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid reset result",    result,             64'd0);
        chk("mid reset result16",  result16,           64'd0);
        chk("mid reset flag_n",    {63'd0, flag_n},    64'd0);
        chk("mid reset flag_z",    {63'd0, flag_z},    64'd0);

        run_op(vecs[0], lat8, lat16);
        chk("post reset result", result, 64'h2A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
